// File: rtl/pool2x2_mover_pkg.sv
// Shared types and constants for the 2x2 pooling data mover.
package pool_pkg;

  // Mover control states; the encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Pooling operation selected by mode_i.
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Registered stages inside one pooling lane (pair sums/maxes, then final).
  localparam int LANE_LAT = 2;

endpackage

// File: rtl/pool2x2_mover_if.sv
// Control, status and BRAM bus bundle of the pooling mover.
// Handshake: start_run_i is a one-cycle request honoured only while idle_o is
// high; done_o is a one-cycle completion pulse. BRAM0 read data arrives one
// cycle after ce_b0_o/addr*_b0_o; a BRAM1 write happens on every cycle with
// ce_b1_o = we_b1_o = 1.
interface pool2x2_mover_if #(
  parameter int NUM_CORE      = 7,
  parameter int IN_DATA_WIDTH = 8,
  parameter int AWIDTH        = 12,
  parameter int CNT_BIT       = 31,
  parameter int DWIDTH        = 2 * NUM_CORE * IN_DATA_WIDTH,
  parameter int DWIDTH_P      = NUM_CORE * IN_DATA_WIDTH
);
  // control
  logic                start_run_i;
  logic [CNT_BIT-1:0]  run_count_i;
  logic                mode_i;
  logic                signed_i;
  // status
  logic                idle_o;
  logic                read_o;
  logic                write_o;
  logic                done_o;
  // BRAM0 (read only)
  logic [AWIDTH-1:0]   addr0_b0_o;
  logic [AWIDTH-1:0]   addr1_b0_o;
  logic                ce_b0_o;
  logic                we_b0_o;
  logic [DWIDTH-1:0]   d_b0_o;
  logic [DWIDTH-1:0]   q_b0_i0;
  logic [DWIDTH-1:0]   q_b0_i1;
  // BRAM1 (write only)
  logic [AWIDTH-1:0]   addr_b1_o;
  logic                ce_b1_o;
  logic                we_b1_o;
  logic [DWIDTH_P-1:0] d_b1_o;

  // The mover side.
  modport master (
    input  start_run_i, run_count_i, mode_i, signed_i, q_b0_i0, q_b0_i1,
    output idle_o, read_o, write_o, done_o,
    output addr0_b0_o, addr1_b0_o, ce_b0_o, we_b0_o, d_b0_o,
    output addr_b1_o, ce_b1_o, we_b1_o, d_b1_o
  );

  // The controller / memory side.
  modport slave (
    output start_run_i, run_count_i, mode_i, signed_i, q_b0_i0, q_b0_i1,
    input  idle_o, read_o, write_o, done_o,
    input  addr0_b0_o, addr1_b0_o, ce_b0_o, we_b0_o, d_b0_o,
    input  addr_b1_o, ce_b1_o, we_b1_o, d_b1_o
  );
endinterface

// File: rtl/pool2x2_mover_lane.sv
// One 2x2 pooling lane: max or rounded average of four elements, two stages.
module pool2x2_lane
  import pool_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_DATA_WIDTH-1:0] a_i,
  input  logic [IN_DATA_WIDTH-1:0] b_i,
  input  logic [IN_DATA_WIDTH-1:0] c_i,
  input  logic [IN_DATA_WIDTH-1:0] d_i,
  input  logic                     mode_i,
  input  logic                     signed_i,
  input  logic                     valid_i,
  output logic [IN_DATA_WIDTH-1:0] result_o,
  output logic                     valid_o
);
  localparam int W  = IN_DATA_WIDTH;
  localparam int SW = IN_DATA_WIDTH + 2;

  // Larger of two elements; flipping the MSB turns a signed compare unsigned.
  function automatic logic [W-1:0] pick_max(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic sg);
    logic [W-1:0] msb;
    msb = {sg, {(W-1){1'b0}}};
    return ((x ^ msb) > (y ^ msb)) ? x : y;
  endfunction

  // Widen an element to the sum width with sign or zero extension.
  function automatic logic [SW-1:0] ext(input logic [W-1:0] x, input logic sg);
    return {{2{sg & x[W-1]}}, x};
  endfunction

  logic [SW-1:0] p1_q, q1_q;
  logic          v1_q;
  logic [SW-1:0] avg_sum;

  // Sum of all four plus the rounding bias; the top W bits are (sum+2)>>>2.
  assign avg_sum = p1_q + q1_q + SW'(2);

  // Stage 1: row-pair partial results (max of a,b / c,d or their sums).
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q <= '0;
      q1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        if (mode_i == MODE_AVG) begin
          p1_q <= ext(a_i, signed_i) + ext(b_i, signed_i);
          q1_q <= ext(c_i, signed_i) + ext(d_i, signed_i);
        end else begin
          p1_q <= {2'b00, pick_max(a_i, b_i, signed_i)};
          q1_q <= {2'b00, pick_max(c_i, d_i, signed_i)};
        end
      end
    end
  end

  // Stage 2: combine the two partials into the lane result.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= v1_q;
      if (v1_q) begin
        if (mode_i == MODE_AVG) result_o <= avg_sum[SW-1:2];
        else                    result_o <= pick_max(p1_q[W-1:0], q1_q[W-1:0], signed_i);
      end
    end
  end

endmodule

// File: rtl/pool2x2_mover.sv
// Parametrised 2x2 pooling mover: reads row pairs from BRAM0, pools them in
// NUM_CORE parallel lanes and writes one word per pair to BRAM1.
module pool2x2_mover
  import pool_pkg::*;
#(
  parameter int NUM_CORE      = 7,
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 2 * NUM_CORE * IN_DATA_WIDTH,
  parameter int DWIDTH_P      = NUM_CORE * IN_DATA_WIDTH,
  parameter int AWIDTH        = 12,
  parameter int CNT_BIT       = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  pool2x2_mover_if.master      bus,
  output state_t               state_dbg_o
);
  localparam int W = IN_DATA_WIDTH;

  state_t             state;
  logic [CNT_BIT-1:0] n_reg;
  logic [CNT_BIT-1:0] rd_cnt;
  logic [CNT_BIT-1:0] wr_cnt;
  logic [AWIDTH-1:0]  rd_addr;
  logic [AWIDTH-1:0]  wr_addr;
  logic               mode_r;
  logic               sgn_r;
  logic               rd_v1;
  logic [NUM_CORE-1:0] lane_valid;
  logic [DWIDTH_P-1:0] lane_result;
  logic               result_valid;

  assign result_valid = &lane_valid;

  // Control FSM plus read/write counters; all outputs derive from these regs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      n_reg   <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      mode_r  <= MODE_MAX;
      sgn_r   <= 1'b0;
      rd_v1   <= 1'b0;
    end else begin
      // BRAM0 data for a read issued this cycle is valid next cycle.
      rd_v1 <= (state == S_RUN);
      // The write side follows the pipeline valid only, never the state.
      if (result_valid) begin
        wr_cnt  <= wr_cnt + CNT_BIT'(1);
        wr_addr <= wr_addr + AWIDTH'(1);
      end
      case (state)
        S_IDLE: begin
          if (bus.start_run_i) begin
            if (bus.run_count_i == '0) begin
              state <= S_DONE;
            end else begin
              state   <= S_RUN;
              n_reg   <= bus.run_count_i;
              mode_r  <= bus.mode_i;
              sgn_r   <= bus.signed_i;
              rd_cnt  <= '0;
              rd_addr <= '0;
              wr_cnt  <= '0;
              wr_addr <= '0;
            end
          end
        end
        S_RUN: begin
          rd_cnt  <= rd_cnt + CNT_BIT'(1);
          rd_addr <= rd_addr + AWIDTH'(2);
          if (rd_cnt == n_reg - CNT_BIT'(1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (result_valid && (wr_cnt == n_reg - CNT_BIT'(1))) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lane j pools bytes 2j+1 / 2j of the even and odd rows.
  for (genvar j = 0; j < NUM_CORE; j++) begin : g_lane
    pool2x2_lane #(.IN_DATA_WIDTH(W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .a_i      (bus.q_b0_i0[(2*j+1)*W +: W]),
      .b_i      (bus.q_b0_i0[(2*j)*W   +: W]),
      .c_i      (bus.q_b0_i1[(2*j+1)*W +: W]),
      .d_i      (bus.q_b0_i1[(2*j)*W   +: W]),
      .mode_i   (mode_r),
      .signed_i (sgn_r),
      .valid_i  (rd_v1),
      .result_o (lane_result[j*W +: W]),
      .valid_o  (lane_valid[j])
    );
  end

  assign state_dbg_o    = state;
  assign bus.idle_o     = (state == S_IDLE);
  assign bus.read_o     = (state == S_RUN);
  assign bus.write_o    = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done_o     = (state == S_DONE);

  assign bus.ce_b0_o    = (state == S_RUN);
  assign bus.we_b0_o    = 1'b0;
  assign bus.d_b0_o     = '0;
  assign bus.addr0_b0_o = (state == S_RUN) ? rd_addr : '0;
  assign bus.addr1_b0_o = (state == S_RUN) ? (rd_addr | AWIDTH'(1)) : '0;

  assign bus.addr_b1_o  = wr_addr;
  assign bus.ce_b1_o    = result_valid;
  assign bus.we_b1_o    = result_valid;
  assign bus.d_b1_o     = lane_result;

endmodule

// File: tb/tb_pool2x2_mover.sv
// Directed bench for pool2x2_mover with an arithmetic reference model.
module tb_pool2x2_mover;
  import pool_pkg::*;

  localparam int NC  = 7;
  localparam int W   = 8;
  localparam int DW  = 2 * NC * W;
  localparam int DWP = NC * W;
  localparam int AW  = 12;
  localparam int CB  = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool2x2_mover_if #(.NUM_CORE(NC), .IN_DATA_WIDTH(W), .AWIDTH(AW), .CNT_BIT(CB)) bus ();
  state_t st;

  pool2x2_mover #(.NUM_CORE(NC), .IN_DATA_WIDTH(W), .AWIDTH(AW), .CNT_BIT(CB)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .state_dbg_o (st)
  );

  // ---------------- memories ----------------
  logic [DW-1:0]  mem [0:63];
  logic [DWP-1:0] wr_mem [0:63];

  always @(posedge clk) begin
    if (bus.ce_b0_o) begin
      bus.q_b0_i0 <= mem[bus.addr0_b0_o[5:0]];
      bus.q_b0_i1 <= mem[bus.addr1_b0_o[5:0]];
    end
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int rd_count, wr_count, done_cyc, last_wr;
  logic [DWP-1:0] last_d;
  logic [AW+DWP-1:0] exp_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int elem(input logic [DW-1:0] w, input int idx, input bit sg);
    logic [W-1:0] v;
    v = w[idx*W +: W];
    if (sg) return int'($signed(v));
    return int'(v);
  endfunction

  function automatic logic [W-1:0] lane_model(input int a, input int b, input int c,
                                              input int d, input bit avg);
    int m;
    int s;
    if (avg) begin
      s = a + b + c + d;
      m = (s + 2) >>> 2;
    end else begin
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
    end
    return m[W-1:0];
  endfunction

  task automatic build_expected(input int n, input bit avg, input bit sg);
    logic [DWP-1:0] word;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < NC; j++)
        word[j*W +: W] = lane_model(elem(mem[2*k], 2*j+1, sg), elem(mem[2*k], 2*j, sg),
                                    elem(mem[2*k+1], 2*j+1, sg), elem(mem[2*k+1], 2*j, sg), avg);
      exp_q.push_back({AW'(k), word});
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [AW+DWP-1:0] e;
    if (!reset) begin
      if (bus.ce_b0_o) begin
        chk("rd_addr0", bus.addr0_b0_o, AW'(2 * rd_count));
        chk("rd_addr1", bus.addr1_b0_o, AW'(2 * rd_count + 1));
        chk("rd_we", bus.we_b0_o, 0);
        rd_count++;
      end
      if (bus.ce_b1_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected addr=%0h data=%0h", bus.addr_b1_o, bus.d_b1_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.addr_b1_o, e[AW+DWP-1:DWP]);
          chk("wr_data", bus.d_b1_o, e[DWP-1:0]);
          chk("wr_we", bus.we_b1_o, 1);
        end
        wr_mem[bus.addr_b1_o[5:0]] = bus.d_b1_o;
        last_d   = bus.d_b1_o;
        last_wr  = cyc - t0;
        wr_count++;
      end
      if (bus.done_o) done_cyc = cyc - t0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    for (int j = 0; j < NC; j++) begin
      mem[0][(2*j+1)*W +: W] = a;
      mem[0][(2*j)*W   +: W] = b;
      mem[1][(2*j+1)*W +: W] = c;
      mem[1][(2*j)*W   +: W] = d;
    end
  endtask

  // Start a run of n words, then follow it to completion with a cycle budget.
  task automatic run(input int n, input bit avg, input bit sg, input bit poke);
    bit done_seen;
    build_expected(n, avg, sg);
    rd_count = 0; wr_count = 0; done_cyc = -1; last_wr = -1;
    done_seen = 0;
    @(negedge clk);
    bus.run_count_i = CB'(n);
    bus.mode_i      = avg;
    bus.signed_i    = sg;
    bus.start_run_i = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start_run_i = 1'b0;
    bus.mode_i      = ~avg;   // mid-run changes must not matter
    bus.signed_i    = ~sg;
    for (int i = 0; i < n + 20; i++) begin
      @(posedge clk); #1;
      bus.start_run_i = poke && (i == 1);
      bus.run_count_i = poke ? CB'(3) : CB'(n);
      if (done_cyc >= 0) begin
        done_seen = 1;
        break;
      end
    end
    bus.start_run_i = 1'b0;
    chk("done_cycle", done_cyc, (n == 0) ? 0 : n + 3);
    chk("idle_after", bus.idle_o & done_seen, 1);
    chk("wr_count", wr_count, n);
    chk("rd_count", rd_count, n);
    chk("exp_left", exp_q.size(), 0);
    if (n > 0) chk("last_wr_cycle", last_wr, n + 2);
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_idle"}, bus.idle_o, 1);
    chk({tag, "_read"}, bus.read_o, 0);
    chk({tag, "_write"}, bus.write_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
    chk({tag, "_ce0"}, bus.ce_b0_o, 0);
    chk({tag, "_addr0"}, bus.addr0_b0_o, 0);
    chk({tag, "_addr1"}, bus.addr1_b0_o, 0);
    chk({tag, "_ce1"}, bus.ce_b1_o, 0);
    chk({tag, "_we1"}, bus.we_b1_o, 0);
    chk({tag, "_addrb1"}, bus.addr_b1_o, 0);
    chk({tag, "_d1"}, bus.d_b1_o, 0);
    chk({tag, "_state"}, st, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0]   bv;
    logic [DWP-1:0] rep;
    reset = 1'b1;
    bus.start_run_i = 1'b0;
    bus.run_count_i = '0;
    bus.mode_i      = 1'b0;
    bus.signed_i    = 1'b0;
    bus.q_b0_i0     = '0;
    bus.q_b0_i1     = '0;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; wr_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    // Hand-computed pins on the reference model itself.
    chk("pin_max_signed",   lane_model(-128, -1, 127, 1, 0), 8'h7F);
    chk("pin_max_unsigned", lane_model(128, 255, 127, 1, 0), 8'hFF);
    chk("pin_avg_up",       lane_model(1, 2, 2, 2, 1), 8'h02);
    chk("pin_avg_down",     lane_model(1, 1, 1, 2, 1), 8'h01);
    chk("pin_avg_signed",   lane_model(-1, -1, -2, -2, 1), 8'hFF);

    // Max unsigned, every byte of row a holds a: word k is all 2k+1.
    for (int a = 0; a < 64; a++) begin
      bv = W'(a);
      mem[a] = {(2*NC){bv}};
    end
    run(4, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      bv  = W'(2 * k + 1);
      rep = {NC{bv}};
      chk("t1_word", wr_mem[k], rep);
    end

    // Single-pair literal cases.
    fill_pair(8'h80, 8'hFF, 8'h7F, 8'h01); run(1, 0, 1, 0);
    bv = 8'h7F; rep = {NC{bv}}; chk("lit_max_signed", last_d, rep);
    run(1, 0, 0, 0);
    bv = 8'hFF; rep = {NC{bv}}; chk("lit_max_unsigned", last_d, rep);
    fill_pair(8'd1, 8'd2, 8'd2, 8'd2); run(1, 1, 0, 0);
    bv = 8'h02; rep = {NC{bv}}; chk("lit_avg_up", last_d, rep);
    fill_pair(8'd1, 8'd1, 8'd1, 8'd2); run(1, 1, 0, 0);
    bv = 8'h01; rep = {NC{bv}}; chk("lit_avg_down", last_d, rep);
    fill_pair(8'hFF, 8'hFF, 8'hFE, 8'hFE); run(1, 1, 1, 0);
    bv = 8'hFF; rep = {NC{bv}}; chk("lit_avg_signed", last_d, rep);

    // Mixed data across lanes in every mode; start poked mid-run once.
    for (int a = 0; a < 64; a++)
      for (int j = 0; j < 2 * NC; j++) mem[a][j*W +: W] = W'($urandom_range(0, 255));
    run(5, 1, 1, 0);
    run(3, 1, 0, 0);
    run(6, 0, 1, 1);
    run(7, 0, 0, 0);

    // Zero-length run: no memory traffic, done right away.
    run(0, 0, 0, 0);

    // Reset in the middle of an N=8 run.
    rd_count = 0; wr_count = 0; done_cyc = -1;
    @(negedge clk);
    bus.run_count_i = CB'(8);
    bus.mode_i      = 1'b0;
    bus.signed_i    = 1'b0;
    bus.start_run_i = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start_run_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;   // cycle 2
    reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("midreset");
    chk("midreset_writes", wr_count, 0);
    reset = 1'b0;
    run(8, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
